ahb_lite_master: RTL and testbench

//  Single-transfer AHB-Lite initiator: turns a simple valid/ready command stream into word

---
 rtl/ahb_lite_master.sv | 167 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master
//  Description : Single-transfer AHB-Lite initiator. Converts a valid/ready
//                command stream into word NONSEQ transfers and returns one
//                in-order response per command. The address phase of the
//                next transfer may overlap the data phase of the current one.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master #(
   parameter int PIPELINED = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   // AHB-Lite master interface
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   // command stream
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   // response stream (no backpressure)
   output logic        rsp_valid,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
   localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
   localparam logic [2:0] c_SIZE_WORD    = 3'b010;
   localparam logic [2:0] c_BURST_SINGLE = 3'b000;
   localparam logic [3:0] c_PROT_DATA    = 4'b0011;

   // Address-phase slot: the transfer currently presented on HADDR/HTRANS
   logic        ap_valid_q, ap_valid_d;
   logic [31:0] ap_addr_q,  ap_addr_d;
   logic        ap_write_q, ap_write_d;
   logic [31:0] ap_wdata_q, ap_wdata_d;

   // Data-phase slot: the transfer waiting for HREADY to complete
   logic        dp_valid_q, dp_valid_d;
   logic        dp_write_q, dp_write_d;
   logic [31:0] hwdata_q,   hwdata_d;

   // Response registers
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_write_q, rsp_write_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_error_q, rsp_error_d;

   logic        w_cmd_ready;
   logic        w_accept;
   logic        w_dp_done;

   // In pipelined mode a new command can replace the address phase on the
   // same edge it retires; otherwise the master waits for both slots to drain.
   generate
      if (PIPELINED != 0) begin : g_pipelined
         assign w_cmd_ready = !ap_valid_q || HREADY;
      end else begin : g_single
         assign w_cmd_ready = !ap_valid_q && !dp_valid_q;
      end
   endgenerate

   assign w_accept  = cmd_valid && w_cmd_ready;
   assign w_dp_done = dp_valid_q && HREADY;

   // Next-state computation for both pipeline slots and the response
   always_comb begin
      ap_valid_d  = ap_valid_q;
      ap_addr_d   = ap_addr_q;
      ap_write_d  = ap_write_q;
      ap_wdata_d  = ap_wdata_q;
      dp_valid_d  = dp_valid_q;
      dp_write_d  = dp_write_q;
      hwdata_d    = hwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;

      // HREADY high ends both phases: whatever sat in the address phase
      // (possibly nothing) becomes the new data phase.
      if (HREADY) begin
         dp_valid_d = ap_valid_q;
         if (ap_valid_q) begin
            dp_write_d = ap_write_q;
            hwdata_d   = ap_wdata_q;
         end
      end

      // A command may load even during a wait state when the address slot
      // is empty; it is then held until HREADY rises.
      if (w_accept) begin
         ap_valid_d = 1'b1;
         ap_addr_d  = {cmd_addr[31:2], 2'b00};
         ap_write_d = cmd_write;
         ap_wdata_d = cmd_write ? cmd_wdata : 32'h0;
      end else if (HREADY) begin
         ap_valid_d = 1'b0;
      end

      if (w_dp_done) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = dp_write_q;
         rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
         rsp_error_d = HRESP;
      end
   end

   // State registers, cleared asynchronously so in-flight work is dropped
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_valid_q  <= 1'b0;
         ap_addr_q   <= 32'h0;
         ap_write_q  <= 1'b0;
         ap_wdata_q  <= 32'h0;
         dp_valid_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         hwdata_q    <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_error_q <= 1'b0;
      end else begin
         ap_valid_q  <= ap_valid_d;
         ap_addr_q   <= ap_addr_d;
         ap_write_q  <= ap_write_d;
         ap_wdata_q  <= ap_wdata_d;
         dp_valid_q  <= dp_valid_d;
         dp_write_q  <= dp_write_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign HADDR     = ap_addr_q;
   assign HTRANS    = ap_valid_q ? c_TRANS_NONSEQ : c_TRANS_IDLE;
   assign HWRITE    = ap_write_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = c_SIZE_WORD;
   assign HBURST    = c_BURST_SINGLE;
   assign HPROT     = c_PROT_DATA;

   assign cmd_ready = w_cmd_ready;

   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_master
//  Description : Self-checking bench for ahb_lite_master (pipelined and
//                non-pipelined instances), directed vectors plus a random
//                command stream against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master;

   localparam int NCMD = 300;

   logic        HCLK;
   logic        HRESETn;

   // pipelined instance
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY, HRESP;
   logic [3:0]  HPROT;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_write, rsp_error;
   logic [31:0] rsp_rdata;

   // non-pipelined instance
   logic [31:0] HADDR_0, HWDATA_0, HRDATA_0;
   logic [2:0]  HSIZE_0, HBURST_0;
   logic [1:0]  HTRANS_0;
   logic        HWRITE_0, HREADY_0, HRESP_0;
   logic [3:0]  HPROT_0;
   logic        cmd_valid_0, cmd_ready_0, cmd_write_0;
   logic [31:0] cmd_addr_0, cmd_wdata_0;
   logic        rsp_valid_0, rsp_write_0, rsp_error_0;
   logic [31:0] rsp_rdata_0;

   int tests = 0;
   int fails = 0;

   ahb_lite_master #(.PIPELINED(1)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HBURST(HBURST), .HPROT(HPROT),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error)
   );

   ahb_lite_master #(.PIPELINED(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HADDR(HADDR_0), .HWDATA(HWDATA_0), .HSIZE(HSIZE_0), .HTRANS(HTRANS_0),
      .HWRITE(HWRITE_0), .HBURST(HBURST_0), .HPROT(HPROT_0),
      .HRDATA(HRDATA_0), .HREADY(HREADY_0), .HRESP(HRESP_0),
      .cmd_valid(cmd_valid_0), .cmd_ready(cmd_ready_0), .cmd_write(cmd_write_0),
      .cmd_addr(cmd_addr_0), .cmd_wdata(cmd_wdata_0),
      .rsp_valid(rsp_valid_0), .rsp_write(rsp_write_0), .rsp_rdata(rsp_rdata_0),
      .rsp_error(rsp_error_0)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_err(input logic [5:0] w);
      return (w % 6'd13) == 6'd5;
   endfunction

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] hrdata;
      logic [31:0] e_haddr;
      logic [31:0] e_rdata;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t        vecs[5];
   exp_t        expq[$];
   exp_t        e;
   logic [31:0] mmem[64];
   logic [31:0] smem[64];

   logic [1:0]  smp_trans, p_trans;
   logic [31:0] smp_addr, smp_wdata, p_addr, p_wdata;
   logic        smp_write, smp_ready, p_write, p_hready, p_ok;
   logic        s_act, s_wr, s_err, accepted;
   logic [5:0]  s_a, a;
   int          s_wait, n_sent, cyc;

   initial begin
      vecs[0] = '{1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 32'h2000_0004, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678};
      vecs[2] = '{1'b1, 32'h0000_0003, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 32'hA5A5_5A5A};
      vecs[4] = '{1'b0, 32'h8000_0002, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0};

      HRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      cmd_valid_0 = 1'b0; cmd_write_0 = 1'b0; cmd_addr_0 = 32'h0; cmd_wdata_0 = 32'h0;
      HREADY_0 = 1'b1; HRESP_0 = 1'b0; HRDATA_0 = 32'h0;

      // ---------------- reset state ----------------
      @(posedge HCLK); #2;
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("rst_cmd_ready_np", 32'(cmd_ready_0), 32'h1);
      chk("hsize", 32'(HSIZE), 32'h2);
      chk("hburst", 32'(HBURST), 32'h0);
      chk("hprot", 32'(HPROT), 32'h3);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // ---------------- table: isolated zero-wait transfers ----------------
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_write = vecs[i].wr;
         cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata;
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0_0000;
         @(negedge HCLK);
         chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'h1);
         @(posedge HCLK); #1;
         cmd_valid = 1'b0;
         @(negedge HCLK);
         chk($sformatf("v%0d_htrans_ap", i), 32'(HTRANS), 32'h2);
         chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].e_haddr);
         chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].wr));
         @(posedge HCLK); #1;
         HRDATA = vecs[i].hrdata;
         @(negedge HCLK);
         chk($sformatf("v%0d_htrans_dp", i), 32'(HTRANS), 32'h0);
         chk($sformatf("v%0d_rsp_early", i), 32'(rsp_valid), 32'h0);
         if (vecs[i].wr) chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].wdata);
         @(posedge HCLK); #1;
         HRDATA = 32'hBAD0_0001;
         @(negedge HCLK);
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
         chk($sformatf("v%0d_rsp_write", i), 32'(rsp_write), 32'(vecs[i].wr));
         chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
         chk($sformatf("v%0d_rsp_error", i), 32'(rsp_error), 32'h0);
         @(posedge HCLK); #1;
         @(negedge HCLK);
         chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 32'h0);
         @(posedge HCLK); #1;
      end

      // ---------------- read/write back-to-back with 2 wait states ----------------
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
      @(posedge HCLK); #1;
      cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'hCAFE_0014;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0; HREADY = 1'b0; HRDATA = 32'hBAD0_BAD0;
      for (int k = 0; k < 3; k++) begin
         @(negedge HCLK);
         chk($sformatf("ws_haddr_%0d", k), HADDR, 32'h14);
         chk($sformatf("ws_htrans_%0d", k), 32'(HTRANS), 32'h2);
         chk($sformatf("ws_hwrite_%0d", k), 32'(HWRITE), 32'h1);
         chk($sformatf("ws_rsp_%0d", k), 32'(rsp_valid), 32'h0);
         if (k == 0) chk("ws_cmd_ready", 32'(cmd_ready), 32'h0);
         @(posedge HCLK); #1;
         if (k == 1) begin HREADY = 1'b1; HRDATA = 32'h1234_5678; end
         if (k == 2) HRDATA = 32'hBAD0_BAD1;
      end
      @(negedge HCLK);
      chk("ws_rsp1_valid", 32'(rsp_valid), 32'h1);
      chk("ws_rsp1_write", 32'(rsp_write), 32'h0);
      chk("ws_rsp1_rdata", rsp_rdata, 32'h1234_5678);
      chk("ws_hwdata", HWDATA, 32'hCAFE_0014);
      chk("ws_htrans_idle", 32'(HTRANS), 32'h0);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("ws_rsp2_valid", 32'(rsp_valid), 32'h1);
      chk("ws_rsp2_write", 32'(rsp_write), 32'h1);
      chk("ws_rsp2_rdata", rsp_rdata, 32'h0);
      @(posedge HCLK); #1;

      // ---------------- two-cycle ERROR then pipelined write ----------------
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
      @(posedge HCLK); #1;
      cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h5555_AAAA;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
      @(negedge HCLK);
      chk("err_htrans_c1", 32'(HTRANS), 32'h2);
      chk("err_haddr_c1", HADDR, 32'h24);
      chk("err_rsp_c1", 32'(rsp_valid), 32'h0);
      @(posedge HCLK); #1;
      HREADY = 1'b1;
      @(negedge HCLK);
      chk("err_htrans_c2", 32'(HTRANS), 32'h2);
      @(posedge HCLK); #1;
      HRESP = 1'b0;
      @(negedge HCLK);
      chk("err_rsp1_valid", 32'(rsp_valid), 32'h1);
      chk("err_rsp1_error", 32'(rsp_error), 32'h1);
      chk("err_rsp1_write", 32'(rsp_write), 32'h0);
      chk("err_hwdata", HWDATA, 32'h5555_AAAA);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("err_rsp2_valid", 32'(rsp_valid), 32'h1);
      chk("err_rsp2_error", 32'(rsp_error), 32'h0);
      chk("err_rsp2_write", 32'(rsp_write), 32'h1);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("err_rsp_done", 32'(rsp_valid), 32'h0);
      @(posedge HCLK); #1;

      // ---------------- non-pipelined: two writes ----------------
      cmd_valid_0 = 1'b1; cmd_write_0 = 1'b1; cmd_addr_0 = 32'h100; cmd_wdata_0 = 32'h1111_1111;
      @(negedge HCLK);
      chk("np_ready_0", 32'(cmd_ready_0), 32'h1);
      @(posedge HCLK); #1;
      cmd_addr_0 = 32'h104; cmd_wdata_0 = 32'h2222_2222;
      @(negedge HCLK);
      chk("np_htrans_1", 32'(HTRANS_0), 32'h2);
      chk("np_haddr_1", HADDR_0, 32'h100);
      chk("np_ready_1", 32'(cmd_ready_0), 32'h0);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("np_htrans_2", 32'(HTRANS_0), 32'h0);
      chk("np_ready_2", 32'(cmd_ready_0), 32'h0);
      chk("np_hwdata_2", HWDATA_0, 32'h1111_1111);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("np_htrans_3", 32'(HTRANS_0), 32'h0);
      chk("np_ready_3", 32'(cmd_ready_0), 32'h1);
      chk("np_rsp_3", 32'(rsp_valid_0), 32'h1);
      chk("np_rsp_write_3", 32'(rsp_write_0), 32'h1);
      @(posedge HCLK); #1;
      cmd_valid_0 = 1'b0;
      @(negedge HCLK);
      chk("np_htrans_4", 32'(HTRANS_0), 32'h2);
      chk("np_haddr_4", HADDR_0, 32'h104);
      chk("np_rsp_4", 32'(rsp_valid_0), 32'h0);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("np_hwdata_5", HWDATA_0, 32'h2222_2222);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk("np_rsp_6", 32'(rsp_valid_0), 32'h1);
      @(posedge HCLK); #1;

      // ---------------- reset asserted during a wait state ----------------
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
      @(posedge HCLK); #1;
      cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h7777_8888;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0; HREADY = 1'b0;
      #2;
      HRESETn = 1'b0;
      #1;
      chk("mrst_htrans", 32'(HTRANS), 32'h0);
      chk("mrst_haddr", HADDR, 32'h0);
      chk("mrst_hwrite", 32'(HWRITE), 32'h0);
      chk("mrst_hwdata", HWDATA, 32'h0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mrst_cmd_ready", 32'(cmd_ready), 32'h1);
      HREADY = 1'b1;
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge HCLK);
         chk($sformatf("mrst_no_rsp_%0d", k), 32'(rsp_valid), 32'h0);
         chk($sformatf("mrst_idle_%0d", k), 32'(HTRANS), 32'h0);
      end
      @(posedge HCLK); #1;

      // ---------------- random stream against transaction model ----------------
      for (int i = 0; i < 64; i++) begin
         mmem[i] = 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B1);
         smem[i] = mmem[i];
      end
      s_act = 1'b0; s_wr = 1'b0; s_err = 1'b0; s_a = 6'd0; s_wait = 0;
      n_sent = 0; cyc = 0; p_ok = 1'b0; p_hready = 1'b1;
      p_trans = 2'b00; p_addr = 32'h0; p_write = 1'b0; p_wdata = 32'h0;
      cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;

      while ((n_sent < NCMD || cmd_valid || expq.size() != 0) && cyc < 6000) begin
         @(negedge HCLK);
         smp_trans = HTRANS; smp_addr = HADDR; smp_write = HWRITE;
         smp_wdata = HWDATA; smp_ready = cmd_ready;
         if (p_ok && !p_hready) begin
            if (p_trans == 2'b10) begin
               chk("rnd_hold_htrans", 32'(smp_trans), 32'(p_trans));
               chk("rnd_hold_haddr", smp_addr, p_addr);
               chk("rnd_hold_hwrite", 32'(smp_write), 32'(p_write));
            end
            if (s_act && s_wr) chk("rnd_hold_hwdata", smp_wdata, p_wdata);
         end
         p_ok = 1'b1; p_hready = HREADY; p_trans = smp_trans;
         p_addr = smp_addr; p_write = smp_write; p_wdata = smp_wdata;
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               tests++; fails++;
               $display("FAIL rnd_rsp_unexpected: got rsp_valid=1, expected no response");
            end else begin
               e = expq.pop_front();
               chk("rnd_rsp_write", 32'(rsp_write), 32'(e.wr));
               chk("rnd_rsp_rdata", rsp_rdata, e.rdata);
               chk("rnd_rsp_error", 32'(rsp_error), 32'(e.err));
            end
         end

         @(posedge HCLK);
         cyc++;
         accepted = 1'b0;
         if (cmd_valid && smp_ready) begin
            a = cmd_addr[7:2];
            e.wr = cmd_write;
            e.err = is_err(a);
            if (cmd_write) begin
               e.rdata = 32'h0;
               if (!e.err) mmem[a] = cmd_wdata;
            end else begin
               e.rdata = mmem[a];
            end
            expq.push_back(e);
            n_sent++;
            accepted = 1'b1;
         end
         if (HREADY) begin
            if (s_act && s_wr && !s_err) smem[s_a] = smp_wdata;
            s_act = (smp_trans == 2'b10);
            s_a = smp_addr[7:2];
            s_wr = smp_write;
            s_err = is_err(s_a);
            if (s_err) s_wait = 1 + int'($urandom_range(1, 0));
            else s_wait = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3, 1));
         end else if (s_act && s_wait > 0) begin
            s_wait--;
         end

         #1;
         if (s_act && s_wait > 0) begin
            HREADY = 1'b0; HRESP = s_err && (s_wait == 1); HRDATA = $urandom;
         end else if (s_act) begin
            HREADY = 1'b1; HRESP = s_err; HRDATA = s_wr ? $urandom : smem[s_a];
         end else begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
         end
         if (accepted) cmd_valid = 1'b0;
         if (!cmd_valid && n_sent < NCMD && $urandom_range(2, 0) != 0) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom_range(1, 0));
            cmd_addr = {24'h0, 6'($urandom_range(63, 0)), 2'($urandom_range(3, 0))};
            cmd_wdata = $urandom;
         end
      end
      chk("rnd_all_sent", 32'(n_sent), 32'(NCMD));
      chk("rnd_all_responded", 32'(expq.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
